regfile_sb: RTL and testbench

Parametrised architectural register file with a per-register pending-write scoreboard, sitting between the decoder/issue stage and the execution writeback path. Commands arrive on a valid/ready channel and answers leave on a buffered response channel, sustaining one command per cycle. A separate always-accepted writeback port retires in-flight writes. Each register has a saturating pending counter, so several outstanding writers to the same register are tracked.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_pend_ctr.sv | 28 ++
 rtl/regfile_sb.sv | 148 ++++++++++++++
 tb/tb_regfile_sb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared opcodes, default widths and the response record for the scoreboarded register file.
package regfile_pkg;

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_MARK  = 2'd2;
    localparam logic [1:0] CMD_CHECK = 2'd3;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_REG_IDX_W  = 4;
    localparam int DEF_PEND_W     = 2;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      err;
    } res_t;

endpackage

// File: rtl/regfile_pend_ctr.sv
// Saturating pending-write counter for one register; clr beats inc/dec, inc+dec cancel.
module regfile_pend_ctr #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] count,
    output logic              at_max,
    output logic              at_zero
);

    logic [PEND_W-1:0] cnt_q;

    assign at_max  = &cnt_q;
    assign at_zero = (cnt_q == '0);
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset)                        cnt_q <= '0;
        else if (clr)                      cnt_q <= '0;
        else if (inc && !dec && !at_max)   cnt_q <= cnt_q + 1'b1;
        else if (dec && !inc && !at_zero)  cnt_q <= cnt_q - 1'b1;
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard, valid/ready command channel
// and a one-deep response buffer. Define REGFILE_SB_BYPASS_EN to forward same-cycle writebacks.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int REG_IDX_W  = DEF_REG_IDX_W,
    parameter int PEND_W     = DEF_PEND_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            i_cmd,
    input  logic [REG_IDX_W-1:0]  i_reg,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_res_data,
    output logic                  o_res_err,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    input  logic                  i_wb_valid,
    input  logic [REG_IDX_W-1:0]  i_wb_reg,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_wb_underflow
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } rsp_t;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [PEND_W-1:0]     cnt    [NUM_REGS];
    logic [NUM_REGS-1:0]   at_max, at_zero, inc_v, dec_v, clr_v;

    rsp_t res_q, res_d;
    logic res_valid_q, uf_q, uf_d;
    logic accept, cmd_inr, wb_inr, same;
    logic [DATA_WIDTH-1:0] cur_val;
    logic [PEND_W-1:0]     cur_cnt;
    logic                  cur_max, cur_zero, wb_zero;

    assign o_ready        = reset && (!res_valid_q || i_res_ready);
    assign accept         = i_valid && o_ready;
    assign cmd_inr        = ({1'b0, i_reg} < (REG_IDX_W+1)'(NUM_REGS));
    assign wb_inr         = ({1'b0, i_wb_reg} < (REG_IDX_W+1)'(NUM_REGS));
    assign same           = cmd_inr && wb_inr && i_wb_valid && (i_reg == i_wb_reg);
    assign o_res_valid    = res_valid_q;
    assign o_res_data     = res_q.data;
    assign o_res_err      = res_q.err;
    assign o_wb_underflow = uf_q;

    always_comb begin
        cur_val  = '0;
        cur_cnt  = '0;
        cur_max  = 1'b0;
        cur_zero = 1'b0;
        wb_zero  = 1'b0;
        inc_v    = '0;
        dec_v    = '0;
        clr_v    = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (i_reg == REG_IDX_W'(r)) begin
                cur_val  = regs_q[r];
                cur_cnt  = cnt[r];
                cur_max  = at_max[r];
                cur_zero = at_zero[r];
                inc_v[r] = accept && (i_cmd == CMD_MARK);
                clr_v[r] = accept && (i_cmd == CMD_WRITE);
            end
            if (i_wb_reg == REG_IDX_W'(r)) begin
                wb_zero  = at_zero[r];
                dec_v[r] = i_wb_valid;
            end
        end
    end

    // A same-cycle MARK or WRITE on the writeback target absorbs the retire, so no underflow.
    assign uf_d = i_wb_valid && (!wb_inr ||
                  (wb_zero && !(accept && same && (i_cmd == CMD_MARK || i_cmd == CMD_WRITE))));

    always_comb begin
        res_d = '0;
        if (!cmd_inr) begin
            res_d.err = 1'b1;
        end else begin
            case (i_cmd)
                CMD_READ: begin
                    res_d.data = cur_val;
`ifdef REGFILE_SB_BYPASS_EN
                    if (same) res_d.data = i_wb_data;
`endif
                end
                CMD_WRITE: res_d.data = i_data;
                CMD_MARK: begin
                    if (same)         res_d.data = DATA_WIDTH'(cur_cnt);
                    else if (cur_max) begin
                        res_d.data = DATA_WIDTH'(cur_cnt);
                        res_d.err  = 1'b1;
                    end else          res_d.data = DATA_WIDTH'(cur_cnt) + DATA_WIDTH'(1);
                end
                default: begin
                    res_d.data = DATA_WIDTH'(cur_cnt);
`ifdef REGFILE_SB_BYPASS_EN
                    if (same && !cur_zero) res_d.data = DATA_WIDTH'(cur_cnt) - DATA_WIDTH'(1);
`endif
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        regfile_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc_v[g]),
            .dec     (dec_v[g]),
            .clr     (clr_v[g]),
            .count   (cnt[g]),
            .at_max  (at_max[g]),
            .at_zero (at_zero[g])
        );

        always_ff @(posedge clk) begin
            if (!reset)        regs_q[g] <= '0;
            else if (clr_v[g]) regs_q[g] <= i_data;
            else if (dec_v[g]) regs_q[g] <= i_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
            uf_q        <= 1'b0;
        end else begin
            uf_q <= uf_d;
            if (accept) begin
                res_valid_q <= 1'b1;
                res_q       <= res_d;
            end else if (i_res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed + randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

    localparam int MAXC = 3;
`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic [1:0]  i_cmd = '0;
    logic [3:0]  i_reg = '0, i_wb_reg = '0;
    logic [31:0] i_data = '0, i_wb_data = '0;
    logic        i_valid = 1'b0, i_res_ready = 1'b0, i_wb_valid = 1'b0;
    logic        o_ready, o_res_err, o_res_valid, o_wb_underflow;
    logic [31:0] o_res_data;

    regfile_sb dut (
        .clk(clk), .reset(reset), .i_cmd(i_cmd), .i_reg(i_reg), .i_data(i_data),
        .i_valid(i_valid), .o_ready(o_ready), .o_res_data(o_res_data),
        .o_res_err(o_res_err), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .i_wb_valid(i_wb_valid), .i_wb_reg(i_wb_reg), .i_wb_data(i_wb_data),
        .o_wb_underflow(o_wb_underflow)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] m_reg [8];
    int          m_cnt [8];
    logic        m_v, m_e, m_uf;
    logic [31:0] m_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, predict, sample #1 after the rising edge.
    task automatic cyc(input logic rn, input logic v, input logic [1:0] cmd, input logic [3:0] rg,
                       input logic [31:0] d, input logic rr,
                       input logic wv, input logic [3:0] wr, input logic [31:0] wd);
        logic acc, inr, winr, same, exp_rdy;
        @(negedge clk);
        reset = rn; i_valid = v; i_cmd = cmd; i_reg = rg; i_data = d; i_res_ready = rr;
        i_wb_valid = wv; i_wb_reg = wr; i_wb_data = wd;
        #1;
        exp_rdy = rn && (!m_v || rr);
        chk("ready", {31'd0, o_ready}, {31'd0, exp_rdy});
        acc  = v && exp_rdy;
        inr  = rg < 8;
        winr = wr < 8;
        same = acc && inr && wv && winr && (rg == wr);
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_cnt[i] = 0; end
            m_v = 0; m_d = '0; m_e = 0; m_uf = 0;
        end else begin
            m_uf = wv && (!winr || (m_cnt[wr[2:0]] == 0 && !(same && (cmd == 1 || cmd == 2))));
            if (acc) begin
                m_v = 1; m_e = 0; m_d = '0;
                if (!inr) m_e = 1;
                else begin
                    int c;
                    c = m_cnt[rg[2:0]];
                    case (cmd)
                        2'd0: m_d = (BYP && same) ? wd : m_reg[rg[2:0]];
                        2'd1: m_d = d;
                        2'd2: if (same) m_d = c; else if (c == MAXC) begin m_d = c; m_e = 1; end
                              else m_d = c + 1;
                        default: m_d = (BYP && same && c > 0) ? c - 1 : c;
                    endcase
                end
            end else if (rr) m_v = 0;
            if (same) begin
                if (cmd == 1) begin m_reg[rg[2:0]] = d; m_cnt[rg[2:0]] = 0; end
                else begin
                    m_reg[wr[2:0]] = wd;
                    if (cmd != 2 && m_cnt[wr[2:0]] > 0) m_cnt[wr[2:0]]--;
                end
            end else begin
                if (acc && inr && cmd == 1) begin m_reg[rg[2:0]] = d; m_cnt[rg[2:0]] = 0; end
                if (acc && inr && cmd == 2 && m_cnt[rg[2:0]] < MAXC) m_cnt[rg[2:0]]++;
                if (wv && winr) begin
                    m_reg[wr[2:0]] = wd;
                    if (m_cnt[wr[2:0]] > 0) m_cnt[wr[2:0]]--;
                end
            end
        end
        #1;
        chk("res_valid", {31'd0, o_res_valid}, {31'd0, m_v});
        if (m_v || !rn) begin
            chk("res_data", o_res_data, m_d);
            chk("res_err", {31'd0, o_res_err}, {31'd0, m_e});
        end
        chk("wb_underflow", {31'd0, o_wb_underflow}, {31'd0, m_uf});
    endtask

    task automatic cmd1(input logic [1:0] cmd, input logic [3:0] rg, input logic [31:0] d);
        cyc(1, 1, cmd, rg, d, 1, 0, 0, 0);
    endtask

    task automatic idle(input logic rr);
        cyc(1, 0, 0, 0, 0, rr, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_cnt[i] = 0; end
        m_v = 0; m_d = '0; m_e = 0; m_uf = 0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("rst_valid", {31'd0, o_res_valid}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            cmd1(3, 4'(r), 0);
            chk("check_rst", o_res_data, 32'd0);
        end
        cmd1(0, 5, 0);
        chk("read5_rst", o_res_data, 32'd0);

        // Back-pressure: response must hold while the consumer stalls.
        cmd1(1, 2, 32'hDEADBEEF);
        cmd1(0, 2, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
            chk("stall_ready", {31'd0, o_ready}, 32'd0);
            chk("stall_data", o_res_data, 32'hDEADBEEF);
        end
        idle(1);

        for (int k = 0; k < 4; k++) begin
            cmd1(2, 3, 0);
            chk("mark3_data", o_res_data, (k < 3) ? 32'(k + 1) : 32'd3);
            chk("mark3_err", {31'd0, o_res_err}, (k < 3) ? 32'd0 : 32'd1);
        end
        cyc(1, 0, 0, 0, 0, 1, 1, 3, 32'h1);
        cyc(1, 0, 0, 0, 0, 1, 1, 3, 32'h2);
        cmd1(3, 3, 0);
        chk("check3", o_res_data, 32'd1);

        cyc(1, 0, 0, 0, 0, 1, 1, 4, 32'hA5A5);
        chk("uf_pulse", {31'd0, o_wb_underflow}, 32'd1);
        idle(1);
        chk("uf_drop", {31'd0, o_wb_underflow}, 32'd0);
        cmd1(0, 4, 0);
        chk("read4", o_res_data, 32'hA5A5);
        cmd1(0, 9, 0);
        chk("oor_err", {31'd0, o_res_err}, 32'd1);
        chk("oor_data", o_res_data, 32'd0);

        for (int k = 0; k < 3; k++) cmd1(2, 1, 0);
        cyc(1, 1, 2, 1, 0, 1, 1, 1, 32'h11);
        chk("markwb_err", {31'd0, o_res_err}, 32'd0);
        cmd1(3, 1, 0);
        chk("markwb_cnt", o_res_data, 32'd3);
        cyc(1, 1, 0, 1, 0, 1, 1, 1, 32'h55);
        chk("read_byp", o_res_data, BYP ? 32'h55 : 32'h11);

        for (int k = 0; k < 16; k++) begin
            cmd1(0, 4'($urandom_range(0, 7)), 0);
            chk("stream_valid", {31'd0, o_res_valid}, 32'd1);
        end
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("midrst_valid", {31'd0, o_res_valid}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            cmd1(3, 4'(r), 0);
            chk("cnt_after_rst", o_res_data, 32'd0);
        end

        // Random traffic, small index range so collisions and saturation are frequent.
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), $urandom,
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0),
                4'($urandom_range(0, 8)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
